button_debouncer: RTL and testbench

//  Synchronises and debounces one raw push-button input from the FPGA board pin.

---
 rtl/button_debouncer.sv | 130 +++++++++++++
 tb/tb_button_debouncer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus four-state debounce FSM for a single push-button.
// Optional held-press detector enabled by defining DEBOUNCE_LONG_PRESS_EN.
module button_debouncer #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_clean,
  output logic btn_busy,
  output logic long_press
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_param_check
    $error("button_debouncer: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   s;
  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic                   clean_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_chain <= '0;
    else       sync_chain <= {sync_chain[SYNC_STAGES-2:0], btn_raw};
  end

  assign s = sync_chain[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_LOW;
      cnt       <= '0;
      btn_clean <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      btn_clean <= clean_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clean_n = btn_clean;
    case (state)
      S_LOW: begin
        clean_n = 1'b0;
        if (s) begin
          state_n = S_RISE;
          cnt_n   = '0;
        end
      end
      S_RISE: begin
        if (!s) begin
          state_n = S_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = S_HIGH;
          clean_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_HIGH: begin
        clean_n = 1'b1;
        if (!s) begin
          state_n = S_FALL;
          cnt_n   = '0;
        end
      end
      S_FALL: begin
        if (s) begin
          state_n = S_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = S_LOW;
          clean_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_LOW;
        cnt_n   = '0;
        clean_n = 1'b0;
      end
    endcase
  end

  assign btn_busy = (state == S_RISE) || (state == S_FALL);

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int LP_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

  logic [LP_W-1:0] lp_cnt;

  // lp_cnt saturates at LP_LAST; it freezes while a release is being qualified.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lp_cnt     <= '0;
      long_press <= 1'b0;
    end else if (state_n == S_LOW) begin
      lp_cnt     <= '0;
      long_press <= 1'b0;
    end else if (state == S_HIGH) begin
      if (lp_cnt != LP_LAST) lp_cnt <= lp_cnt + 1'b1;
      else                   long_press <= 1'b1;
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with a windowed behavioural model checked every cycle.
module tb_button_debouncer;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LP   = 10;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic btn_raw;
  logic btn_clean, btn_busy, long_press;

  int checks = 0;
  int errors = 0;

  button_debouncer #(
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_clean (btn_clean),
    .btn_busy  (btn_busy),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: btn_clean flips once the last DEB+1 synchronised samples all disagree with it;
  // long_press once LP edges have started with the output settled high.
  bit raw_hist[$];
  bit s_hist[$];
  bit m_clean, m_busy, m_lp;
  int hi_edges;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_hist.delete();
      s_hist.delete();
      m_clean  = 1'b0;
      m_busy   = 1'b0;
      m_lp     = 1'b0;
      hi_edges = 0;
    end else begin
      bit s, was_high, flip;
      was_high = m_clean && !m_busy;
      s = (raw_hist.size() >= SYNC) ? raw_hist[raw_hist.size() - SYNC] : 1'b0;
      raw_hist.push_back(btn_raw);
      if (raw_hist.size() > 16) void'(raw_hist.pop_front());
      s_hist.push_back(s);
      if (s_hist.size() > DEB + 1) void'(s_hist.pop_front());
      flip = (s_hist.size() == DEB + 1);
      foreach (s_hist[i]) if (s_hist[i] == m_clean) flip = 1'b0;
      if (was_high) hi_edges++;
      if (flip) begin
        m_clean = !m_clean;
        if (!m_clean) hi_edges = 0;
      end
      m_busy = (s != m_clean);
      m_lp   = LP_EN && m_clean && (hi_edges >= LP);
    end
  end

  always @(negedge clk) begin
    cmp("model_clean", btn_clean, m_clean);
    cmp("model_busy", btn_busy, m_busy);
    cmp("model_long_press", long_press, m_lp);
  end

  task automatic at_edge(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    btn_raw = 1'b1;

    // Held through reset: outputs low, then full latency after release.
    at_edge(3);
    cmp("rst_clean", btn_clean, 1'b0);
    cmp("rst_busy", btn_busy, 1'b0);
    cmp("rst_long_press", long_press, 1'b0);
    @(negedge clk) reset = 1'b0;
    at_edge(6);
    cmp("hold_rst_e6_clean", btn_clean, 1'b0);
    at_edge(1);
    cmp("hold_rst_e7_clean", btn_clean, 1'b1);
    cmp("hold_rst_e7_busy", btn_busy, 1'b0);
    @(negedge clk) btn_raw = 1'b0;
    at_edge(12);
    cmp("released_clean", btn_clean, 1'b0);

    // Clean press held, with long-press timing.
    @(negedge clk) btn_raw = 1'b1;
    at_edge(2);
    cmp("press_e2_busy", btn_busy, 1'b0);
    at_edge(1);
    cmp("press_e3_busy", btn_busy, 1'b1);
    cmp("press_e3_clean", btn_clean, 1'b0);
    at_edge(3);
    cmp("press_e6_clean", btn_clean, 1'b0);
    cmp("press_e6_busy", btn_busy, 1'b1);
    at_edge(1);
    cmp("press_e7_clean", btn_clean, 1'b1);
    cmp("press_e7_busy", btn_busy, 1'b0);
    at_edge(9);
    cmp("press_e16_long_press", long_press, 1'b0);
    at_edge(1);
    cmp("press_e17_long_press", long_press, LP_EN);
    at_edge(3);

    // Release with one bounce back high.
    @(negedge clk) btn_raw = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) btn_raw = 1'b1;
    @(posedge clk);
    @(negedge clk) btn_raw = 1'b0;
    at_edge(6);
    cmp("bounce_e6_clean", btn_clean, 1'b1);
    cmp("bounce_e6_long_press", long_press, LP_EN);
    at_edge(1);
    cmp("bounce_e7_clean", btn_clean, 1'b0);
    cmp("bounce_e7_long_press", long_press, 1'b0);
    cmp("bounce_e7_busy", btn_busy, 1'b0);
    at_edge(4);

    // Short glitch is rejected.
    @(negedge clk) btn_raw = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) btn_raw = 1'b0;
    at_edge(2);
    cmp("glitch_e5_busy", btn_busy, 1'b1);
    cmp("glitch_e5_clean", btn_clean, 1'b0);
    at_edge(1);
    cmp("glitch_e6_busy", btn_busy, 1'b0);
    at_edge(4);
    cmp("glitch_e10_clean", btn_clean, 1'b0);

    // Asynchronous reset in the middle of qualification.
    @(negedge clk) btn_raw = 1'b1;
    at_edge(5);
    cmp("midrst_pre_busy", btn_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    cmp("midrst_clean", btn_clean, 1'b0);
    cmp("midrst_busy", btn_busy, 1'b0);
    cmp("midrst_long_press", long_press, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    at_edge(6);
    cmp("midrst_e6_clean", btn_clean, 1'b0);
    cmp("midrst_e6_busy", btn_busy, 1'b1);
    at_edge(1);
    cmp("midrst_e7_clean", btn_clean, 1'b1);

    @(negedge clk) btn_raw = 1'b0;
    at_edge(10);
    cmp("final_clean", btn_clean, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
